fibonacci_gen: RTL and testbench
================================

Name: fibonacci_gen

Overview:
- Forward Fibonacci generator: accepts an index n over a valid/ready handshake and returns F(n), with F(0)=0, F(1)=1, F(2)=1, ….
- Counterpart of the existing number-to-index search block. Pairs with it in the same datapath so software can round-trip index <-> number.
- Iterative: one addition per cycle, one request in flight.
- Flags overflow when F(n) does not fit in WIDTH bits.

Parameters:
- WIDTH, 64, result width in bits (unsigned).
- IDX_W, 7, index input width.
- MAX_INDEX, 93, largest n with F(n) < 2^WIDTH. Must equal fib_max_index(WIDTH) from the package (93 for 64, 47 for 32); an elaboration-time assertion checks this.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- index  in  IDX_W  requested Fibonacci index n.
- valid  in  1  request strobe; accepted when valid && ready.
- ready  out  1  high when idle and able to accept. Combinational from state only; never depends on valid.
- number  out  WIDTH  F(n), registered. Holds its value until the next result.
- overflow  out  1  registered; meaningful while number_valid=1.
- number_valid  out  1  single-cycle result pulse.

Behaviour:
- Reset (async assert, sync release) forces:
  - state=IDLE, number=0, overflow=0, number_valid=0;
  - internal a=1, b=1, cnt=2, idx_reg=0.
- States: IDLE, CALC.
- ready=1 exactly when state==IDLE.
- IDLE, request accepted at cycle T (valid=1):
  - n==0: number<=0, overflow<=0, number_valid<=1. Stay IDLE.
  - n==1: number<=1, overflow<=0, number_valid<=1. Stay IDLE.
  - n>MAX_INDEX: number<=0, overflow<=1, number_valid<=1. Stay IDLE.
  - otherwise: idx_reg<=n, a<=1, b<=1, cnt<=2, go to CALC.
- CALC:
  - if cnt==idx_reg: number<=b, overflow<=0, number_valid<=1, a<=1, b<=1, cnt<=2, go to IDLE.
  - else: a<=b, b<=a+b (WIDTH-bit; cannot wrap because n<=MAX_INDEX), cnt<=cnt+1.
- Latency from the accept cycle T to number_valid:
  - n in {0,1} or n>MAX_INDEX: valid at T+1.
  - 2<=n<=MAX_INDEX: valid at T+n.
- Throughput:
  - n in {0,1} or overflow: back-to-back accepts every cycle.
  - other n: next accept no earlier than the cycle number_valid is high (ready=1 again in that cycle).
- valid while ready=0 is ignored; the request is not queued. index is sampled only on accept.
- number_valid is low in every cycle that does not deliver a result.
- Reset mid-CALC aborts the request silently; no number_valid is emitted.

Optional Feature:
- Macro: FIB_GEN_CACHE_EN.
- Defined:
  - Store the last delivered in-range (n, F(n)) pair; the cache is invalid after reset.
  - In IDLE, an accepted n equal to the cached n (cache valid, 2<=n<=MAX_INDEX) returns the cached value at T+1 and stays in IDLE.
  - Overflow requests and n in {0,1} never update the cache.
- Undefined: no cache storage; every request follows the normal latency.

Decomposition:
- Package fibonacci_pkg:
  - state enum fib_state_t {IDLE, CALC};
  - default WIDTH and IDX_W localparams;
  - constant function fib_max_index(width), which iterates F until F >= 2^width.
- No sub-module needed: the datapath is two registers, one adder and a counter, all inline.

Test Plan:
- Reset, then index=0 at T -> number_valid at T+1 with number=0, overflow=0. Then index=1 on the very next cycle -> number=1 at T+2.
- index=10 at T -> ready low T+1..T+9; number=55 with number_valid at T+10.
- index=93 -> number=12200160415121876738 at T+93, overflow=0. Then index=94 -> number=0, overflow=1 at T+1.
- index=20 accepted, then valid pulses with index=5 during CALC -> ignored; only number=6765 is delivered.
- index=50 accepted, rst_n pulsed low at T+10 -> all outputs 0 immediately, no number_valid; a fresh index=3 returns 2 at T'+3.
- (FIB_GEN_CACHE_EN) index=30 -> 832040 at T+30, then index=30 again -> 832040 at T'+1; index=31 -> 1346269 at T'+31.

Source files
------------

// File: rtl/fibonacci_pkg.sv
// Shared types and sizing helpers for the Fibonacci generator.
package fibonacci_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } fib_state_t;

  localparam int FIB_WIDTH = 64;
  localparam int FIB_IDX_W = 7;

  // Largest n with F(n) < 2^width. Walks the sequence until it reaches 2^width.
  // Wide scratch registers keep the walk exact up to 128-bit results.
  function automatic int fib_max_index(input int width);
    logic [129:0] lim;
    logic [129:0] f_prev;
    logic [129:0] f_cur;
    logic [129:0] f_tmp;
    int           n;
    lim    = 130'd1 << width;
    f_prev = '0;
    f_cur  = 130'd1;
    n      = 1;
    while (f_cur < lim) begin
      f_tmp  = f_prev + f_cur;
      f_prev = f_cur;
      f_cur  = f_tmp;
      n      = n + 1;
    end
    return n - 1;
  endfunction

endpackage

// File: rtl/fibonacci_gen_if.sv
// Request/response bundle between a requester and the Fibonacci generator.
interface fibonacci_gen_if
  import fibonacci_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH,
  parameter int IDX_W = FIB_IDX_W
);

  logic [IDX_W-1:0] index;
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] number;
  logic             overflow;
  logic             number_valid;

  modport master (
    output index, valid,
    input  ready, number, overflow, number_valid
  );

  modport slave (
    input  index, valid,
    output ready, number, overflow, number_valid
  );

endinterface

// File: rtl/fibonacci_gen.sv
// Iterative forward Fibonacci generator: index in, F(index) out, one add per cycle.
// Optional result cache of the last delivered in-range pair: define FIB_GEN_CACHE_EN.
//
// state | meaning
// IDLE  | ready for a request; 0, 1, out-of-range (and cache hits) answered here
// CALC  | stepping a/b until cnt reaches the requested index
module fibonacci_gen
  import fibonacci_pkg::*;
#(
  parameter int WIDTH     = FIB_WIDTH,
  parameter int IDX_W     = FIB_IDX_W,
  parameter int MAX_INDEX = 93
) (
  input  logic          clk,
  input  logic          rst_n,
  fibonacci_gen_if.slave bus
);

  if (MAX_INDEX != fib_max_index(WIDTH)) begin : g_bad_max_index
    $error("fibonacci_gen: MAX_INDEX does not match fib_max_index(WIDTH)");
  end

  fib_state_t       state, state_nxt;
  logic [WIDTH-1:0] a, a_nxt;
  logic [WIDTH-1:0] b, b_nxt;
  logic [IDX_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] idx_reg, idx_reg_nxt;
  logic [WIDTH-1:0] number_q, number_nxt;
  logic             overflow_q, overflow_nxt;
  logic             nvalid_q, nvalid_nxt;

`ifdef FIB_GEN_CACHE_EN
  logic             cache_vld, cache_vld_nxt;
  logic [IDX_W-1:0] cache_idx, cache_idx_nxt;
  logic [WIDTH-1:0] cache_val, cache_val_nxt;
`endif

  assign bus.ready        = (state == IDLE);
  assign bus.number       = number_q;
  assign bus.overflow     = overflow_q;
  assign bus.number_valid = nvalid_q;

  // Next-state and datapath decode; everything holds unless a branch says otherwise.
  always_comb begin
    state_nxt    = state;
    a_nxt        = a;
    b_nxt        = b;
    cnt_nxt      = cnt;
    idx_reg_nxt  = idx_reg;
    number_nxt   = number_q;
    overflow_nxt = overflow_q;
    nvalid_nxt   = 1'b0;
`ifdef FIB_GEN_CACHE_EN
    cache_vld_nxt = cache_vld;
    cache_idx_nxt = cache_idx;
    cache_val_nxt = cache_val;
`endif
    case (state)
      IDLE: begin
        if (bus.valid) begin
          if (bus.index == '0) begin
            number_nxt   = '0;
            overflow_nxt = 1'b0;
            nvalid_nxt   = 1'b1;
          end else if (bus.index == IDX_W'(1)) begin
            number_nxt   = WIDTH'(1);
            overflow_nxt = 1'b0;
            nvalid_nxt   = 1'b1;
          end else if (int'(bus.index) > MAX_INDEX) begin
            number_nxt   = '0;
            overflow_nxt = 1'b1;
            nvalid_nxt   = 1'b1;
`ifdef FIB_GEN_CACHE_EN
          // Only in-range n >= 2 is ever cached, so a hit needs no range test.
          end else if (cache_vld && (bus.index == cache_idx)) begin
            number_nxt   = cache_val;
            overflow_nxt = 1'b0;
            nvalid_nxt   = 1'b1;
`endif
          end else begin
            idx_reg_nxt = bus.index;
            a_nxt       = WIDTH'(1);
            b_nxt       = WIDTH'(1);
            cnt_nxt     = IDX_W'(2);
            state_nxt   = CALC;
          end
        end
      end
      CALC: begin
        if (cnt == idx_reg) begin
          number_nxt   = b;
          overflow_nxt = 1'b0;
          nvalid_nxt   = 1'b1;
          a_nxt        = WIDTH'(1);
          b_nxt        = WIDTH'(1);
          cnt_nxt      = IDX_W'(2);
          state_nxt    = IDLE;
`ifdef FIB_GEN_CACHE_EN
          cache_vld_nxt = 1'b1;
          cache_idx_nxt = idx_reg;
          cache_val_nxt = b;
`endif
        end else begin
          // b holds F(cnt); the add cannot wrap while n stays within MAX_INDEX.
          a_nxt   = b;
          b_nxt   = a + b;
          cnt_nxt = cnt + IDX_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a          <= WIDTH'(1);
      b          <= WIDTH'(1);
      cnt        <= IDX_W'(2);
      idx_reg    <= '0;
      number_q   <= '0;
      overflow_q <= 1'b0;
      nvalid_q   <= 1'b0;
    end else begin
      a          <= a_nxt;
      b          <= b_nxt;
      cnt        <= cnt_nxt;
      idx_reg    <= idx_reg_nxt;
      number_q   <= number_nxt;
      overflow_q <= overflow_nxt;
      nvalid_q   <= nvalid_nxt;
    end
  end

`ifdef FIB_GEN_CACHE_EN
  // Last delivered in-range result; invalid after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_vld <= 1'b0;
      cache_idx <= '0;
      cache_val <= '0;
    end else begin
      cache_vld <= cache_vld_nxt;
      cache_idx <= cache_idx_nxt;
      cache_val <= cache_val_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_fibonacci_gen.sv
// Directed bench for fibonacci_gen; cache checks are built when FIB_GEN_CACHE_EN is defined.
module tb_fibonacci_gen;

  localparam int WIDTH = 64;
  localparam int IDX_W = 7;
  localparam int LIMIT = 200;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  fibonacci_gen_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

  fibonacci_gen #(.WIDTH(WIDTH), .IDX_W(IDX_W), .MAX_INDEX(93)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request once ready, hold it through the accepting edge, then drop valid.
  task automatic accept(input logic [IDX_W-1:0] n);
    int k;
    k = 0;
    while (!bus.ready && k < LIMIT) begin
      tick();
      k++;
    end
    if (k >= LIMIT) chk_eq("ready_timeout", 64'(bus.ready), 64'd1);
    bus.index = n;
    bus.valid = 1'b1;
    tick();
    bus.valid = 1'b0;
  endtask

  // Called right after the accept edge; lat counts edges from accept (1 = next cycle).
  task automatic wait_nv(input int start, output int lat);
    lat = start;
    while (!bus.number_valid && lat < LIMIT) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_one(input string tag, input logic [IDX_W-1:0] n,
                         input logic [63:0] exp_num, input logic exp_ovf, input int exp_lat);
    int lat;
    accept(n);
    wait_nv(1, lat);
    chk_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk_eq({tag, "_num"}, bus.number, exp_num);
    chk_eq({tag, "_ovf"}, 64'(bus.overflow), 64'(exp_ovf));
  endtask

  typedef struct {
    logic [IDX_W-1:0] n;
    logic [63:0]      f;
    logic             ovf;
    int               lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat;
    int low_ok;
    checks   = 0;
    failures = 0;
    rst_n     = 1'b0;
    bus.valid = 1'b0;
    bus.index = '0;

    vecs[0] = '{n: 7'd2,   f: 64'd1,          ovf: 1'b0, lat: 2};
    vecs[1] = '{n: 7'd3,   f: 64'd2,          ovf: 1'b0, lat: 3};
    vecs[2] = '{n: 7'd12,  f: 64'd144,        ovf: 1'b0, lat: 12};
    vecs[3] = '{n: 7'd47,  f: 64'd2971215073, ovf: 1'b0, lat: 47};
    vecs[4] = '{n: 7'd127, f: 64'd0,          ovf: 1'b1, lat: 1};
    vecs[5] = '{n: 7'd64,  f: 64'd10610209857723, ovf: 1'b0, lat: 64};

    #23;
    chk_eq("rst_number", bus.number, 64'd0);
    chk_eq("rst_ovf", 64'(bus.overflow), 64'd0);
    chk_eq("rst_nv", 64'(bus.number_valid), 64'd0);
    chk_eq("rst_ready", 64'(bus.ready), 64'd1);
    rst_n = 1'b1;
    tick();

    // n=0 then n=1 on the very next cycle
    run_one("n0", 7'd0, 64'd0, 1'b0, 1);
    run_one("n1", 7'd1, 64'd1, 1'b0, 1);
    tick();
    chk_eq("nv_single", 64'(bus.number_valid), 64'd0);

    // n=10: ready and number_valid low for nine cycles, result on the tenth edge
    accept(7'd10);
    low_ok = 1;
    for (int i = 1; i <= 9; i++) begin
      if (bus.ready || bus.number_valid) low_ok = 0;
      if (i < 9) tick();
    end
    chk_eq("n10_busy", 64'(low_ok), 64'd1);
    tick();
    chk_eq("n10_nv", 64'(bus.number_valid), 64'd1);
    chk_eq("n10_num", bus.number, 64'd55);
    chk_eq("n10_ready", 64'(bus.ready), 64'd1);

    // boundary: largest in-range index, then first overflowing one back to back
    run_one("n93", 7'd93, 64'd12200160415121876738, 1'b0, 93);
    run_one("n94", 7'd94, 64'd0, 1'b1, 1);
    tick();
    chk_eq("n94_hold_num", bus.number, 64'd0);
    chk_eq("n94_nv_drop", 64'(bus.number_valid), 64'd0);

    foreach (vecs[i]) begin
      run_one($sformatf("vec%0d", vecs[i].n), vecs[i].n, vecs[i].f, vecs[i].ovf, vecs[i].lat);
    end

    // valid pulses during CALC must be ignored
    accept(7'd20);
    tick();
    bus.index = 7'd5;
    bus.valid = 1'b1;
    tick();
    bus.valid = 1'b0;
    tick();
    bus.valid = 1'b1;
    tick();
    bus.valid = 1'b0;
    wait_nv(5, lat);
    chk_eq("ign_lat", 64'(lat), 64'd20);
    chk_eq("ign_num", bus.number, 64'd6765);
    low_ok = 1;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus.number_valid) low_ok = 0;
    end
    chk_eq("ign_no_extra", 64'(low_ok), 64'd1);

    // reset mid-CALC aborts silently
    accept(7'd50);
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    chk_eq("abort_num", bus.number, 64'd0);
    chk_eq("abort_nv", 64'(bus.number_valid), 64'd0);
    chk_eq("abort_ready", 64'(bus.ready), 64'd1);
    tick();
    tick();
    rst_n = 1'b1;
    low_ok = 1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.number_valid) low_ok = 0;
    end
    chk_eq("abort_silent", 64'(low_ok), 64'd1);
    run_one("post_n3", 7'd3, 64'd2, 1'b0, 3);

`ifdef FIB_GEN_CACHE_EN
    run_one("c30a", 7'd30, 64'd832040, 1'b0, 30);
    run_one("c30b", 7'd30, 64'd832040, 1'b0, 1);
    run_one("c31", 7'd31, 64'd1346269, 1'b0, 31);
    run_one("c0", 7'd0, 64'd0, 1'b0, 1);
    run_one("c31b", 7'd31, 64'd1346269, 1'b0, 1);
`else
    run_one("r30a", 7'd30, 64'd832040, 1'b0, 30);
    run_one("r30b", 7'd30, 64'd832040, 1'b0, 30);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
